// File: rtl/bsg_ddr_req_to_fifo_pkg.sv
// Package bsg_ddr_fifo_pkg: shared types and constants for the DDR request front-end.
//   ddr_cmd_s : 26-bit command word layout as written into the cmd FIFO
//   Op*       : {cs_n,ras_n,cas_n,we_n} opcodes for LMR / ACT / RD / WR
//   state_e   : request front-end FSM states
//   bl_code() : burst length -> mode-register BL field
package bsg_ddr_fifo_pkg;

   typedef struct packed {
      logic [2:0]  bank;
      logic [15:0] addr;
      logic        cke;
      logic        cs_n;
      logic        ras_n;
      logic        cas_n;
      logic        we_n;
      logic        reset_n;
      logic        odt;
   } ddr_cmd_s;

   localparam logic [3:0] OpLmr = 4'b0000;
   localparam logic [3:0] OpAct = 4'b0011;
   localparam logic [3:0] OpRd  = 4'b0101;
   localparam logic [3:0] OpWr  = 4'b0100;

   typedef enum logic [2:0] {
      eInit,
      eIdle,
      eAct,
      eCmd,
      eWrData,
      eRdData
   } state_e;

   function automatic logic [2:0] bl_code(int unsigned bl);
      case (bl)
         2:       return 3'b001;
         4:       return 3'b010;
         8:       return 3'b011;
         16:      return 3'b100;
         default: return 3'b011;
      endcase
   endfunction

endpackage

// File: rtl/bsg_ddr_req_to_fifo_if.sv
// Interface bsg_ddr_req_to_fifo_if: every handshake/bus signal of the DDR request front-end.
// Signal names carry the direction as seen from the front-end (the block under the slave modport).
//   request side : req_*, wdata_*/wmask_i, rdata_*
//   FIFO side    : fifo_cmd_*, fifo_wr_*, fifo_rd_*
// Modports: slave = the front-end itself, master = requester plus FIFOs driving it.
interface bsg_ddr_req_to_fifo_if #(
   parameter int unsigned dq_data_width_p = 16,
   parameter int unsigned addr_width_p    = 29
);
   localparam int unsigned word_width_lp = 2 * dq_data_width_p;
   localparam int unsigned mask_width_lp = word_width_lp / 8;

   logic                                   req_v_i;
   logic                                   req_write_i;
   logic [addr_width_p-1:0]                req_addr_i;
   logic                                   req_ready_o;

   logic                                   wdata_v_i;
   logic [word_width_lp-1:0]               wdata_i;
   logic [mask_width_lp-1:0]               wmask_i;
   logic                                   wdata_ready_o;

   logic                                   rdata_v_o;
   logic [word_width_lp-1:0]               rdata_o;
   logic                                   rdata_yumi_i;

   logic                                   fifo_cmd_v_o;
   logic [25:0]                            fifo_cmd_data_o;
   logic                                   fifo_cmd_ready_i;

   logic                                   fifo_wr_v_o;
   logic [word_width_lp+mask_width_lp-1:0] fifo_wr_data_o;
   logic                                   fifo_wr_ready_i;

   logic                                   fifo_rd_v_i;
   logic [word_width_lp-1:0]               fifo_rd_data_i;
   logic                                   fifo_rd_yumi_o;

   modport slave (
      input  req_v_i, req_write_i, req_addr_i,
      output req_ready_o,
      input  wdata_v_i, wdata_i, wmask_i,
      output wdata_ready_o,
      output rdata_v_o, rdata_o,
      input  rdata_yumi_i,
      output fifo_cmd_v_o, fifo_cmd_data_o,
      input  fifo_cmd_ready_i,
      output fifo_wr_v_o, fifo_wr_data_o,
      input  fifo_wr_ready_i,
      input  fifo_rd_v_i, fifo_rd_data_i,
      output fifo_rd_yumi_o
   );

   modport master (
      output req_v_i, req_write_i, req_addr_i,
      input  req_ready_o,
      output wdata_v_i, wdata_i, wmask_i,
      input  wdata_ready_o,
      input  rdata_v_o, rdata_o,
      output rdata_yumi_i,
      input  fifo_cmd_v_o, fifo_cmd_data_o,
      output fifo_cmd_ready_i,
      input  fifo_wr_v_o, fifo_wr_data_o,
      output fifo_wr_ready_i,
      output fifo_rd_v_i, fifo_rd_data_i,
      input  fifo_rd_yumi_o
   );

endinterface

// File: rtl/bsg_ddr_cmd_encode.sv
// bsg_ddr_cmd_encode: combinational builder of one 26-bit DDR command word.
//   op_i   : {cs_n,ras_n,cas_n,we_n} opcode (OpLmr/OpAct/OpRd/OpWr)
//   bank_i : 2-bit bank (ignored for LMR, which always targets bank 0)
//   row_i  : row address used by ACT
//   col_i  : column address used by RD/WR
//   mode_i : mode-register value used by LMR
//   cmd_o  : {bank[2:0],addr[15:0],cke,cs_n,ras_n,cas_n,we_n,reset_n,odt}
module bsg_ddr_cmd_encode
   import bsg_ddr_fifo_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [1:0]  bank_i,
   input  logic [13:0] row_i,
   input  logic [10:0] col_i,
   input  logic [15:0] mode_i,
   output logic [25:0] cmd_o
);

   ddr_cmd_s cmd;

   always_comb begin
      cmd         = '0;
      cmd.cke     = 1'b1;
      cmd.reset_n = 1'b1;
      cmd.odt     = 1'b0;
      {cmd.cs_n, cmd.ras_n, cmd.cas_n, cmd.we_n} = op_i;
      case (op_i)
         OpLmr: begin
            cmd.bank = 3'b000;
            cmd.addr = mode_i;
         end
         OpAct: begin
            cmd.bank = {1'b0, bank_i};
            cmd.addr = {2'b00, row_i};
         end
         default: begin
            // RD/WR: A10 forced low so the row stays open (no auto-precharge).
            cmd.bank = {1'b0, bank_i};
            cmd.addr = {4'b0000, col_i[10], 1'b0, col_i[9:0]};
         end
      endcase
      cmd_o = cmd;
   end

endmodule

// File: rtl/bsg_ddr_req_to_fifo.sv
// bsg_ddr_req_to_fifo: upstream front-end of the DDR-command-FIFO-to-AXI bridge.
// After reset issues one Load-Mode-Register, then serves one read/write burst request at a time:
// ACT + RD/WR command words into the cmd FIFO, then burst_len_p/2 data words streamed between
// the requester and the wr/rd FIFOs.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   bus (slave)      : request, write-data, read-data and FIFO handshakes
//   busy_o           : high whenever the FSM is not idle
// Build option: define BSG_DDR_REQ_OPEN_ROW_EN to track the last activated bank/row and skip ACT
// on a matching request; without it every request issues ACT.
module bsg_ddr_req_to_fifo
   import bsg_ddr_fifo_pkg::*;
#(
   parameter int unsigned dq_data_width_p = 16,
   parameter int unsigned burst_len_p     = 8,
   parameter int unsigned cas_latency_p   = 3,
   parameter int unsigned addr_width_p    = 29
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   bsg_ddr_req_to_fifo_if.slave  bus,
   output logic                  busy_o
);

   localparam int unsigned words_lp     = burst_len_p / 2;
   localparam int unsigned cnt_width_lp = $clog2(words_lp + 1);
   localparam logic [cnt_width_lp-1:0] words_cnt_lp = cnt_width_lp'(words_lp);
   localparam logic [15:0] mode_lp = {9'b0, 3'(cas_latency_p), 1'b0, bl_code(burst_len_p)};

   state_e                  state_q;
   logic                    write_q;
   logic [1:0]              bank_q;
   logic [13:0]             row_q;
   logic [10:0]             col_q;
   logic [cnt_width_lp-1:0] cnt_q;
   logic                    cmd_v_q;
   logic [25:0]             cmd_data_q;

   logic [1:0]  req_bank;
   logic [13:0] req_row;
   logic [10:0] req_col;
   logic        unused_addr_lsbs;

   assign req_bank         = bus.req_addr_i[28:27];
   assign req_row          = bus.req_addr_i[26:13];
   assign req_col          = bus.req_addr_i[12:2];
   assign unused_addr_lsbs = ^bus.req_addr_i[1:0];

   logic accept, row_hit, wr_xfer, rd_xfer, cmd_fire;
   logic [cnt_width_lp-1:0] cnt_inc;

   assign accept   = (state_q == eIdle) & bus.req_v_i;
   assign wr_xfer  = (state_q == eWrData) & bus.wdata_v_i & bus.fifo_wr_ready_i;
   assign rd_xfer  = (state_q == eRdData) & bus.fifo_rd_v_i & bus.rdata_yumi_i;
   assign cmd_fire = cmd_v_q & bus.fifo_cmd_ready_i;
   assign cnt_inc  = cnt_q + cnt_width_lp'(1);

`ifdef BSG_DDR_REQ_OPEN_ROW_EN
   logic        tag_v_q;
   logic [1:0]  tag_bank_q;
   logic [13:0] tag_row_q;

   assign row_hit = tag_v_q & (tag_bank_q == req_bank) & (tag_row_q == req_row);

   // A miss always issues ACT, so the tag is refreshed at acceptance.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tag_v_q    <= 1'b0;
         tag_bank_q <= '0;
         tag_row_q  <= '0;
      end else if (accept && !row_hit) begin
         tag_v_q    <= 1'b1;
         tag_bank_q <= req_bank;
         tag_row_q  <= req_row;
      end
   end
`else
   assign row_hit = 1'b0;
`endif

   // Encoder inputs: in eIdle the request has not been latched yet, so use it directly.
   logic [3:0]  enc_op, rw_op;
   logic [1:0]  enc_bank;
   logic [13:0] enc_row;
   logic [10:0] enc_col;
   logic        enc_write;
   logic [25:0] enc_cmd;

   always_comb begin
      enc_bank  = bank_q;
      enc_row   = row_q;
      enc_col   = col_q;
      enc_write = write_q;
      if (state_q == eIdle) begin
         enc_bank  = req_bank;
         enc_row   = req_row;
         enc_col   = req_col;
         enc_write = bus.req_write_i;
      end
      rw_op = enc_write ? OpWr : OpRd;
      case (state_q)
         eInit:   enc_op = OpLmr;
         eIdle:   enc_op = row_hit ? rw_op : OpAct;
         default: enc_op = rw_op;
      endcase
   end

   bsg_ddr_cmd_encode u_encode (
      .op_i   (enc_op),
      .bank_i (enc_bank),
      .row_i  (enc_row),
      .col_i  (enc_col),
      .mode_i (mode_lp),
      .cmd_o  (enc_cmd)
   );

   // Command word is loaded on entry to the state that owns it and held until the FIFO takes it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= eInit;
         write_q    <= 1'b0;
         bank_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         cmd_v_q    <= 1'b0;
         cmd_data_q <= '0;
      end else begin
         case (state_q)
            eInit: begin
               if (!cmd_v_q) begin
                  cmd_v_q    <= 1'b1;
                  cmd_data_q <= enc_cmd;
               end else if (bus.fifo_cmd_ready_i) begin
                  cmd_v_q <= 1'b0;
                  state_q <= eIdle;
               end
            end
            eIdle: begin
               if (accept) begin
                  write_q    <= bus.req_write_i;
                  bank_q     <= req_bank;
                  row_q      <= req_row;
                  col_q      <= req_col;
                  cmd_v_q    <= 1'b1;
                  cmd_data_q <= enc_cmd;
                  state_q    <= row_hit ? eCmd : eAct;
               end
            end
            eAct: begin
               if (cmd_fire) begin
                  cmd_data_q <= enc_cmd;
                  state_q    <= eCmd;
               end
            end
            eCmd: begin
               if (cmd_fire) begin
                  cmd_v_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= write_q ? eWrData : eRdData;
               end
            end
            eWrData: begin
               if (wr_xfer) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == words_cnt_lp) state_q <= eIdle;
               end
            end
            eRdData: begin
               if (rd_xfer) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == words_cnt_lp) state_q <= eIdle;
               end
            end
            default: begin
               state_q <= eInit;
               cmd_v_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready_o     = (state_q == eIdle);
   assign bus.fifo_cmd_v_o    = cmd_v_q;
   assign bus.fifo_cmd_data_o = cmd_data_q;

   assign bus.fifo_wr_v_o    = (state_q == eWrData) & bus.wdata_v_i;
   assign bus.wdata_ready_o  = (state_q == eWrData) & bus.fifo_wr_ready_i;
   assign bus.fifo_wr_data_o = {bus.wdata_i, bus.wmask_i};

   assign bus.rdata_v_o      = (state_q == eRdData) & bus.fifo_rd_v_i;
   assign bus.rdata_o        = bus.fifo_rd_data_i;
   assign bus.fifo_rd_yumi_o = rd_xfer;

   assign busy_o = (state_q != eIdle);

endmodule

// File: tb/tb_bsg_ddr_req_to_fifo.sv
// Directed testbench for bsg_ddr_req_to_fifo (default parameters: DQ16, BL8, CL3).
module tb_bsg_ddr_req_to_fifo;

   localparam logic [3:0] LMR = 4'b0000;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;

   logic clk;
   logic reset_n;
   logic busy;

   int n_checks = 0;
   int n_fail   = 0;

   bsg_ddr_req_to_fifo_if #(.dq_data_width_p(16), .addr_width_p(29)) bus ();

   bsg_ddr_req_to_fifo #(
      .dq_data_width_p (16),
      .burst_len_p     (8),
      .cas_latency_p   (3),
      .addr_width_p    (29)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus),
      .busy_o    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected cmd word: {bank, addr, cke=1, op, reset_n=1, odt=0}.
   function automatic logic [25:0] cw(logic [2:0] bank, logic [15:0] addr, logic [3:0] op);
      return {bank, addr, 1'b1, op, 1'b1, 1'b0};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd_words [4];
   int k;

   initial begin
      rd_words[0] = 32'h1111_0001;
      rd_words[1] = 32'h2222_0002;
      rd_words[2] = 32'h3333_0003;
      rd_words[3] = 32'h4444_0004;

      reset_n              = 1'b0;
      bus.req_v_i          = 1'b0;
      bus.req_write_i      = 1'b0;
      bus.req_addr_i       = '0;
      bus.wdata_v_i        = 1'b0;
      bus.wdata_i          = '0;
      bus.wmask_i          = '0;
      bus.rdata_yumi_i     = 1'b0;
      bus.fifo_cmd_ready_i = 1'b1;
      bus.fifo_wr_ready_i  = 1'b1;
      bus.fifo_rd_v_i      = 1'b0;
      bus.fifo_rd_data_i   = '0;

      // Reset state
      repeat (2) step();
      chk("rst_cmd_v", bus.fifo_cmd_v_o, 1'b0);
      chk("rst_cmd_data", bus.fifo_cmd_data_o, 26'h0);
      chk("rst_req_ready", bus.req_ready_o, 1'b0);
      chk("rst_busy", busy, 1'b1);

      // 1: LMR after release, CL3 BL8 -> addr 0x0033
      reset_n = 1'b1;
      step();
      chk("lmr_v", bus.fifo_cmd_v_o, 1'b1);
      chk("lmr_word", bus.fifo_cmd_data_o, cw(3'd0, 16'h0033, LMR));
      chk("lmr_req_ready", bus.req_ready_o, 1'b0);
      step();
      chk("idle_cmd_v", bus.fifo_cmd_v_o, 1'b0);
      chk("idle_req_ready", bus.req_ready_o, 1'b1);
      chk("idle_busy", busy, 1'b0);

      // 2: write burst, bank0 row1 col1
      bus.req_v_i     = 1'b1;
      bus.req_write_i = 1'b1;
      bus.req_addr_i  = 29'h0000_2004;
      step();
      bus.req_v_i = 1'b0;
      chk("wr_act_v", bus.fifo_cmd_v_o, 1'b1);
      chk("wr_act_word", bus.fifo_cmd_data_o, cw(3'd0, 16'h0001, ACT));
      chk("wr_req_ready", bus.req_ready_o, 1'b0);
      step();
      chk("wr_cmd_word", bus.fifo_cmd_data_o, cw(3'd0, 16'h0001, WR));
      step();
      chk("wr_cmd_done", bus.fifo_cmd_v_o, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.wdata_v_i = 1'b1;
         bus.wdata_i   = 32'hA0A0_0000 + 32'(i);
         bus.wmask_i   = 4'(i + 3);
         #1;
         chk("wr_fifo_v", bus.fifo_wr_v_o, 1'b1);
         chk("wr_ready", bus.wdata_ready_o, 1'b1);
         chk("wr_fifo_data", bus.fifo_wr_data_o, {32'hA0A0_0000 + 32'(i), 4'(i + 3)});
         step();
      end
      bus.wdata_i = 32'hDEAD_BEEF;
      #1;
      chk("wr_5th_ready", bus.wdata_ready_o, 1'b0);
      chk("wr_5th_fifo_v", bus.fifo_wr_v_o, 1'b0);
      chk("wr_back_idle", bus.req_ready_o, 1'b1);
      bus.wdata_v_i = 1'b0;

      // 3: read burst bank1 row0 col0, yumi on alternate cycles
      bus.req_v_i     = 1'b1;
      bus.req_write_i = 1'b0;
      bus.req_addr_i  = 29'h0800_0000;
      step();
      bus.req_v_i = 1'b0;
      chk("rd_act_word", bus.fifo_cmd_data_o, cw(3'd1, 16'h0000, ACT));
      step();
      chk("rd_cmd_word", bus.fifo_cmd_data_o, cw(3'd1, 16'h0000, RD));
      step();
      bus.fifo_rd_v_i = 1'b1;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         bus.rdata_yumi_i   = (i % 2) == 1;
         bus.fifo_rd_data_i = rd_words[k];
         #1;
         chk("rd_v", bus.rdata_v_o, 1'b1);
         chk("rd_data", bus.rdata_o, rd_words[k]);
         chk("rd_yumi", bus.fifo_rd_yumi_o, bus.rdata_yumi_i);
         step();
         if (bus.rdata_yumi_i) k++;
      end
      bus.rdata_yumi_i = 1'b1;
      #1;
      chk("rd_done_busy", busy, 1'b0);
      chk("rd_done_v", bus.rdata_v_o, 1'b0);
      chk("rd_done_yumi", bus.fifo_rd_yumi_o, 1'b0);
      bus.rdata_yumi_i = 1'b0;
      bus.fifo_rd_v_i  = 1'b0;

      // 4: cmd FIFO stalled during ACT (write bank1 row2 col2)
      bus.fifo_cmd_ready_i = 1'b0;
      bus.req_v_i          = 1'b1;
      bus.req_write_i      = 1'b1;
      bus.req_addr_i       = 29'h0800_4008;
      step();
      bus.req_v_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_v", bus.fifo_cmd_v_o, 1'b1);
         chk("stall_word", bus.fifo_cmd_data_o, cw(3'd1, 16'h0002, ACT));
         chk("stall_req_ready", bus.req_ready_o, 1'b0);
         step();
      end
      bus.fifo_cmd_ready_i = 1'b1;
      #1;
      chk("stall_hold", bus.fifo_cmd_data_o, cw(3'd1, 16'h0002, ACT));
      step();
      chk("stall_wr_word", bus.fifo_cmd_data_o, cw(3'd1, 16'h0002, WR));
      step();

      // 5: reset in the middle of the write data phase
      bus.wdata_v_i = 1'b1;
      repeat (2) step();
      bus.fifo_rd_v_i = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_wr_v", bus.fifo_wr_v_o, 1'b0);
      chk("arst_wr_ready", bus.wdata_ready_o, 1'b0);
      chk("arst_cmd_v", bus.fifo_cmd_v_o, 1'b0);
      chk("arst_req_ready", bus.req_ready_o, 1'b0);
      chk("arst_rd_v", bus.rdata_v_o, 1'b0);
      bus.wdata_v_i   = 1'b0;
      bus.fifo_rd_v_i = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("relmr_word", bus.fifo_cmd_data_o, cw(3'd0, 16'h0033, LMR));
      step();
      chk("relmr_idle", bus.req_ready_o, 1'b1);

      // 6: two reads to bank0 row1
      bus.req_v_i     = 1'b1;
      bus.req_write_i = 1'b0;
      bus.req_addr_i  = 29'h0000_2000;
      step();
      bus.req_v_i = 1'b0;
      chk("or1_act", bus.fifo_cmd_data_o, cw(3'd0, 16'h0001, ACT));
      step();
      chk("or1_rd", bus.fifo_cmd_data_o, cw(3'd0, 16'h0000, RD));
      step();
      bus.fifo_rd_v_i  = 1'b1;
      bus.rdata_yumi_i = 1'b1;
      repeat (4) step();
      chk("or1_done", busy, 1'b0);
      bus.fifo_rd_v_i  = 1'b0;
      bus.rdata_yumi_i = 1'b0;

      bus.req_v_i    = 1'b1;
      bus.req_addr_i = 29'h0000_2010;
      step();
      bus.req_v_i = 1'b0;
`ifdef BSG_DDR_REQ_OPEN_ROW_EN
      chk("or2_rd_only", bus.fifo_cmd_data_o, cw(3'd0, 16'h0004, RD));
`else
      chk("or2_act", bus.fifo_cmd_data_o, cw(3'd0, 16'h0001, ACT));
      step();
      chk("or2_rd", bus.fifo_cmd_data_o, cw(3'd0, 16'h0004, RD));
`endif
      step();
      bus.fifo_rd_v_i  = 1'b1;
      bus.rdata_yumi_i = 1'b1;
      repeat (4) step();
      chk("or2_done", busy, 1'b0);
      bus.fifo_rd_v_i  = 1'b0;
      bus.rdata_yumi_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
